// File: rtl/max_pool_3_stream_pkg.sv
// Feature-map constants shared by the conv2d_4 and max-pool stages.
package max_pool_3_stream_pkg;

  localparam int unsigned FM_DATA_W   = 35;
  localparam int unsigned FM_WIDTH    = 8;
  localparam int unsigned FM_HEIGHT   = 8;
  localparam int unsigned FM_CHANNELS = 64;

endpackage

// File: rtl/max_pool_3_stream_fm_max2.sv
// Signed two-input maximum; on a tie both inputs are equal so either is returned.
module fm_max2 #(
  parameter int unsigned DATA_W = 35
) (
  input  logic signed [DATA_W-1:0] i_a,
  input  logic signed [DATA_W-1:0] i_b,
  output logic signed [DATA_W-1:0] o_max_c
);

  assign o_max_c = (i_a >= i_b) ? i_a : i_b;

endmodule

// File: rtl/max_pool_3_stream.sv
// Streaming 2x2/stride-2 max pool over channel-major raster feature maps.
// One pair register plus a half-row line buffer; single output register with backpressure.
module max_pool_3_stream
  import max_pool_3_stream_pkg::*;
#(
  parameter int unsigned WIDTH    = FM_WIDTH,
  parameter int unsigned HEIGHT   = FM_HEIGHT,
  parameter int unsigned CHANNELS = FM_CHANNELS,
  parameter int unsigned DATA_W   = FM_DATA_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_W-1:0]     in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_W-1:0]     out_data,
  output logic [$clog2(CHANNELS)-1:0]  out_ch,
  output logic                         out_last,
  output logic                         frame_done
);

  localparam int unsigned COL_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned ROW_W    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int unsigned CH_W     = $clog2(CHANNELS);
  localparam int unsigned LB_DEPTH = WIDTH / 2;
  localparam int unsigned LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

  logic [COL_W-1:0]         r_col;
  logic [ROW_W-1:0]         r_row;
  logic [CH_W-1:0]          r_ch;
  logic signed [DATA_W-1:0] r_pair;
  logic signed [DATA_W-1:0] r_lb [LB_DEPTH];
  logic                     r_out_valid;
  logic signed [DATA_W-1:0] r_out_data;
  logic [CH_W-1:0]          r_out_ch;
  logic                     r_out_last;
  logic                     r_frame_done;

  logic                     w_fire;
  logic                     w_emit;
  logic                     w_last_col;
  logic                     w_last_row;
  logic                     w_last_ch;
  logic [LB_AW-1:0]         w_lb_idx;
  logic signed [DATA_W-1:0] w_hmax;
  logic signed [DATA_W-1:0] w_vmax;

  assign w_last_col = (r_col == COL_W'(WIDTH - 1));
  assign w_last_row = (r_row == ROW_W'(HEIGHT - 1));
  assign w_last_ch  = (r_ch == CH_W'(CHANNELS - 1));
  assign w_emit     = r_row[0] & r_col[0];
  assign w_lb_idx   = LB_AW'(r_col >> 1);

  // Only a result-completing beat can stall, and only when the output slot is blocked.
  assign in_ready   = ~(w_emit & r_out_valid & ~out_ready);
  assign w_fire     = in_valid & in_ready;

  fm_max2 #(.DATA_W(DATA_W)) u_hmax (
    .i_a     (r_pair),
    .i_b     (in_data),
    .o_max_c (w_hmax)
  );

  fm_max2 #(.DATA_W(DATA_W)) u_vmax (
    .i_a     (w_hmax),
    .i_b     (r_lb[w_lb_idx]),
    .o_max_c (w_vmax)
  );

  // Raster counters, pair register and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_col        <= '0;
      r_row        <= '0;
      r_ch         <= '0;
      r_pair       <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_ch     <= '0;
      r_out_last   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      if (w_fire) begin
        if (!r_col[0]) begin
          r_pair <= in_data;
        end
        if (w_last_col) begin
          r_col <= '0;
          if (w_last_row) begin
            r_row <= '0;
            r_ch  <= w_last_ch ? '0 : r_ch + CH_W'(1);
          end else begin
            r_row <= r_row + ROW_W'(1);
          end
        end else begin
          r_col <= r_col + COL_W'(1);
        end
      end

      // A new load wins over a same-cycle drain, so back-to-back results have no bubble.
      if (w_fire && w_emit) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_vmax;
        r_out_ch    <= r_ch;
        r_out_last  <= w_last_col & w_last_row & w_last_ch;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end

      r_frame_done <= r_out_valid & out_ready & r_out_last;
    end
  end

  // Line buffer: each entry is written on an even row before its odd-row read, so no reset.
  always_ff @(posedge clk) begin
    if (w_fire && r_col[0] && !r_row[0]) begin
      r_lb[w_lb_idx] <= w_hmax;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_ch     = r_out_ch;
  assign out_last   = r_out_last;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_max_pool_3_stream.sv
// Self-checking bench for max_pool_3_stream: window table, directed corners and random frames vs a max-pool model.
module tb_max_pool_3_stream;
  import max_pool_3_stream_pkg::*;

  localparam int unsigned W     = FM_WIDTH;
  localparam int unsigned H     = FM_HEIGHT;
  localparam int unsigned C     = FM_CHANNELS;
  localparam int unsigned DW    = FM_DATA_W;
  localparam int unsigned CW    = $clog2(C);
  localparam int unsigned N_IN  = W * H * C;
  localparam int unsigned PW    = W / 2;
  localparam int unsigned PH    = H / 2;
  localparam int unsigned OPC   = PW * PH;
  localparam int unsigned N_OUT = C * OPC;
  localparam int unsigned NV    = 8;

  typedef logic signed [DW-1:0] smp_t;
  typedef struct {
    smp_t data;
    int   ch;
    bit   last;
  } out_t;
  typedef struct {
    smp_t a;
    smp_t b;
    smp_t c;
    smp_t d;
    smp_t exp;
  } vec_t;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  smp_t          in_data;
  logic          out_valid;
  logic          out_ready;
  smp_t          out_data;
  logic [CW-1:0] out_ch;
  logic          out_last;
  logic          frame_done;

  max_pool_3_stream dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_ch     (out_ch),
    .out_last   (out_last),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  smp_t fr [N_IN];
  out_t got [$];
  out_t exp_q [$];
  vec_t tbl [NV];
  int   fd_cnt = 0;
  bit   prev_last_xfer = 1'b0;
  bit   rand_bp = 1'b0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic int idx(input int ch, input int r, input int c);
    return (ch * H + r) * W + c;
  endfunction

  function automatic vec_t mk(input longint a, input longint b, input longint c,
                              input longint d, input longint e);
    vec_t v;
    v.a = DW'(a); v.b = DW'(b); v.c = DW'(c); v.d = DW'(d); v.exp = DW'(e);
    return v;
  endfunction

  function automatic smp_t rnd_nonneg();
    if ($urandom_range(0, 3) == 0) return smp_t'($urandom_range(0, 3));
    return {1'b0, 2'($urandom), $urandom};
  endfunction

  task automatic fill_zero();
    foreach (fr[i]) fr[i] = '0;
  endtask

  task automatic fill_random();
    foreach (fr[i]) fr[i] = rnd_nonneg();
  endtask

  // Reference: plain 2x2 stride-2 maximum over each map, emitted in raster order.
  task automatic build_model();
    for (int ch = 0; ch < int'(C); ch++)
      for (int pr = 0; pr < int'(PH); pr++)
        for (int pc = 0; pc < int'(PW); pc++) begin
          out_t o;
          smp_t m;
          m = fr[idx(ch, 2 * pr, 2 * pc)];
          for (int dy = 0; dy < 2; dy++)
            for (int dx = 0; dx < 2; dx++)
              if (fr[idx(ch, 2 * pr + dy, 2 * pc + dx)] > m) m = fr[idx(ch, 2 * pr + dy, 2 * pc + dx)];
          o.data = m;
          o.ch   = ch;
          o.last = (ch == int'(C) - 1) && (pr == int'(PH) - 1) && (pc == int'(PW) - 1);
          exp_q.push_back(o);
        end
  endtask

  // Output monitor: records every transfer and checks frame_done follows the out_last transfer.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (out_valid && out_ready) begin
        out_t o;
        o.data = out_data;
        o.ch   = int'(out_ch);
        o.last = out_last;
        got.push_back(o);
      end
      if (frame_done || prev_last_xfer) check("frame_done_timing", longint'(frame_done), longint'(prev_last_xfer));
      if (frame_done) fd_cnt++;
      prev_last_xfer = out_valid && out_ready && out_last;
    end
  end

  task automatic send(input smp_t d, output bit ok);
    bit rdy;
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
      #1;
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        ok = 1'b1;
        return;
      end
    end
    check("send_timeout", 0, 1);
  endtask

  task automatic send_range(input int from, input int to);
    bit ok;
    for (int i = from; i <= to; i++) begin
      send(fr[i], ok);
      if (!ok) return;
    end
  endtask

  task automatic drain();
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic compare_outputs(input string tag);
    int n;
    check({tag, "_count"}, got.size(), exp_q.size());
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_data"}, longint'(got[i].data), longint'(exp_q[i].data));
      check({tag, "_ch"},   got[i].ch,             exp_q[i].ch);
      check({tag, "_last"}, longint'(got[i].last), longint'(exp_q[i].last));
    end
    got.delete();
    exp_q.delete();
  endtask

  initial begin
    int   p;
    int   stall_cnt;
    int   nz;
    int   lasts;
    bit   ok;
    smp_t held;
    int   held_ch;
    smp_t maxp;

    tbl[0] = mk(3, 9, 7, 2, 9);
    tbl[1] = mk(42, 42, 42, 42, 42);
    tbl[2] = mk(-5, -3, -9, -1, -1);
    tbl[3] = mk(-1, 0, 0, 0, 0);
    tbl[4] = mk(1, 0, 0, 0, 1);
    tbl[5] = mk(0, 0, 0, 100, 100);
    tbl[6] = mk(64'sh3_FFFF_FFFF, -64'sh4_0000_0000, 5, 5, 64'sh3_FFFF_FFFF);
    tbl[7] = mk(-100, -200, -300, -50, -50);
    maxp   = DW'(64'sh3_FFFF_FFFF);

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid",  longint'(out_valid),  0);
    check("rst_out_data",   longint'(out_data),   0);
    check("rst_out_ch",     longint'(out_ch),     0);
    check("rst_out_last",   longint'(out_last),   0);
    check("rst_frame_done", longint'(frame_done), 0);
    check("rst_in_ready",   longint'(in_ready),   1);

    // Table windows at map k, window 0; first-result latency checked on map 0.
    fill_zero();
    for (int k = 0; k < int'(NV); k++) begin
      fr[idx(k, 0, 0)] = tbl[k].a;
      fr[idx(k, 0, 1)] = tbl[k].b;
      fr[idx(k, 1, 0)] = tbl[k].c;
      fr[idx(k, 1, 1)] = tbl[k].d;
    end
    build_model();
    send_range(0, W);
    check("lat_before_valid", longint'(out_valid), 0);
    send(fr[W + 1], ok);
    check("lat_valid", longint'(out_valid), 1);
    check("lat_data",  longint'(out_data),  9);
    check("lat_ch",    longint'(out_ch),    0);
    send_range(W + 2, N_IN - 1);
    drain();
    for (int k = 0; k < int'(NV); k++) begin
      if (got.size() > k * OPC) check($sformatf("tbl%0d", k), longint'(got[k * OPC].data), longint'(tbl[k].exp));
      else check($sformatf("tbl%0d_missing", k), got.size(), k * OPC + 1);
    end
    compare_outputs("tbl_frame");

    // Single largest positive value in the last window of map 5.
    fill_zero();
    fr[idx(5, H - 1, W - 1)] = maxp;
    build_model();
    send_range(0, N_IN - 1);
    drain();
    nz = 0;
    foreach (got[i]) if (got[i].data != 0) nz++;
    check("posmax_nonzero_cnt", nz, 1);
    if (got.size() > 5 * OPC + OPC - 1) check("posmax_value", longint'(got[5 * OPC + OPC - 1].data), longint'(maxp));
    else check("posmax_missing", got.size(), N_OUT);
    compare_outputs("posmax_frame");

    // Output blocked for 20 cycles after the first result.
    fill_random();
    build_model();
    send_range(0, W + 1);
    out_ready = 1'b0;
    held      = exp_q[0].data;
    held_ch   = exp_q[0].ch;
    p         = W + 2;
    stall_cnt = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      bit rdy;
      bit exp_rdy;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = fr[p];
      #1;
      rdy     = in_ready;
      exp_rdy = !((((p / W) % H) % 2 == 1) && ((p % W) % 2 == 1));
      check("bp_in_ready",  longint'(rdy),       longint'(exp_rdy));
      check("bp_out_valid", longint'(out_valid), 1);
      check("bp_out_data",  longint'(out_data),  longint'(held));
      check("bp_out_ch",    longint'(out_ch),    held_ch);
      if (!rdy) stall_cnt++;
      @(posedge clk);
      #1;
      if (rdy) p++;
    end
    check("bp_stall_seen", longint'(stall_cnt > 0), 1);
    out_ready = 1'b1;
    send_range(p, N_IN - 1);
    drain();
    compare_outputs("bp_frame");

    // Two random frames back-to-back under random output backpressure.
    fd_cnt = 0;
    rand_bp = 1'b1;
    fill_random();
    build_model();
    send_range(0, N_IN - 1);
    fill_random();
    build_model();
    send_range(0, N_IN - 1);
    rand_bp = 1'b0;
    drain();
    lasts = 0;
    foreach (got[i]) if (got[i].last) lasts++;
    check("b2b_last_cnt", lasts, 2);
    check("b2b_frame_done_cnt", fd_cnt, 2);
    if (got.size() >= N_OUT) check("b2b_first_frame_last", longint'(got[N_OUT - 1].last), 1);
    else check("b2b_first_frame_missing", got.size(), N_OUT);
    compare_outputs("b2b");

    // Reset with a result pending at map 10, row 3, column 1; next frame starts clean.
    fill_random();
    send_range(0, idx(10, 3, 1) - 1);
    out_ready = 1'b0;
    send(fr[idx(10, 3, 1)], ok);
    check("mid_pending_valid", longint'(out_valid), 1);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    got.delete();
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      #1;
      check("post_rst_no_valid", longint'(out_valid), 0);
      @(negedge clk);
    end
    fill_random();
    build_model();
    send_range(0, N_IN - 1);
    drain();
    if (got.size() > 0) begin
      check("post_rst_first_ch",   got[0].ch,             0);
      check("post_rst_first_data", longint'(got[0].data), longint'(exp_q[0].data));
    end else check("post_rst_no_output", 0, 1);
    compare_outputs("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
